// File: rtl/cpu_execute_stage_if.sv
// Signal bundle of the execute stage: decode->execute register, execute->memory register,
// and the stall/flush handshake with the neighbouring pipeline stages.
interface cpu_execute_stage_if #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
);
    logic                ex_valid;
    logic [1:0]          ex_alu_op;
    logic                ex_is_mul;
    logic                ex_reg_b;
    logic [XLEN-1:0]     ex_ra_data;
    logic [XLEN-1:0]     ex_rb_data;
    logic [XLEN-1:0]     ex_offset;
    logic [REG_BITS-1:0] ex_reg_dest;
    logic                ex_commit;
    logic                ex_mem_to_reg;
    logic                ex_reg_write;
    logic                flush;
    logic                mem_stall;
    logic                stall;
    logic                mem_valid;
    logic [XLEN-1:0]     mem_result;
    logic [XLEN-1:0]     mem_store_data;
    logic [REG_BITS-1:0] mem_reg_dest;
    logic                mem_commit;
    logic                mem_mem_to_reg;
    logic                mem_reg_write;

    modport slave (
        input  ex_valid, ex_alu_op, ex_is_mul, ex_reg_b, ex_ra_data, ex_rb_data, ex_offset,
               ex_reg_dest, ex_commit, ex_mem_to_reg, ex_reg_write, flush, mem_stall,
        output stall, mem_valid, mem_result, mem_store_data, mem_reg_dest, mem_commit,
               mem_mem_to_reg, mem_reg_write
    );

    modport master (
        output ex_valid, ex_alu_op, ex_is_mul, ex_reg_b, ex_ra_data, ex_rb_data, ex_offset,
               ex_reg_dest, ex_commit, ex_mem_to_reg, ex_reg_write, flush, mem_stall,
        input  stall, mem_valid, mem_result, mem_store_data, mem_reg_dest, mem_commit,
               mem_mem_to_reg, mem_reg_write
    );
endinterface

// File: rtl/cpu_execute_stage.sv
// Execute stage: single-cycle ADD/SUB/AND/OR plus an XLEN-cycle shift-add multiplier,
// feeding the execute->memory register and stalling upstream while a MUL is in flight.
module cpu_execute_stage #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input  logic               clock,
    input  logic               reset,
    cpu_execute_stage_if.slave bus
);
    localparam int CNT_BITS = $clog2(XLEN);
    localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [XLEN-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
    logic [XLEN-1:0]     cap_store_q, cap_store_d;
    logic [REG_BITS-1:0] cap_dest_q, cap_dest_d;
    logic                cap_commit_q, cap_commit_d, cap_m2r_q, cap_m2r_d, cap_rw_q, cap_rw_d;
    logic                valid_q, valid_d, commit_q, commit_d, m2r_q, m2r_d, rw_q, rw_d;
    logic [XLEN-1:0]     result_q, result_d, store_q, store_d;
    logic [REG_BITS-1:0] dest_q, dest_d;
    logic [XLEN-1:0]     opb_s, alu_s;
    logic                mul_accept_s, stall_s;

    function automatic logic [XLEN-1:0] alu_f(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            2'b11:   return a | b;
            default: return a + b;
        endcase
    endfunction

    assign opb_s        = bus.ex_reg_b ? bus.ex_rb_data : bus.ex_offset;
    assign alu_s        = alu_f(bus.ex_alu_op, bus.ex_ra_data, opb_s);
    assign mul_accept_s = (state_q == IDLE) && bus.ex_valid && bus.ex_is_mul && !bus.flush;
    assign stall_s      = !reset && (bus.mem_stall ||
                          (!bus.flush && ((state_q == BUSY) || mul_accept_s)));

    // Multiplier FSM and datapath next state; a flush always returns to IDLE.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        acc_d        = acc_q;
        cap_store_d  = cap_store_q;
        cap_dest_d   = cap_dest_q;
        cap_commit_d = cap_commit_q;
        cap_m2r_d    = cap_m2r_q;
        cap_rw_d     = cap_rw_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_accept_s) begin
                        state_d      = BUSY;
                        count_d      = {CNT_BITS{1'b0}};
                        mul_a_d      = bus.ex_ra_data;
                        mul_b_d      = opb_s;
                        acc_d        = {XLEN{1'b0}};
                        cap_store_d  = bus.ex_rb_data;
                        cap_dest_d   = bus.ex_reg_dest;
                        cap_commit_d = bus.ex_commit;
                        cap_m2r_d    = bus.ex_mem_to_reg;
                        cap_rw_d     = bus.ex_reg_write;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    if (mul_b_q[0]) begin
                        acc_d = acc_q + mul_a_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    mul_a_d = mul_a_q << 1;
                    mul_b_d = mul_b_q >> 1;
                    count_d = count_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
                    if (count_q == LAST_STEP) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
                DONE: begin
                    if (bus.mem_stall) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Execute->memory register: hold on mem_stall, bubble on flush/MUL-in-flight.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        store_d  = store_q;
        dest_d   = dest_q;
        commit_d = commit_q;
        m2r_d    = m2r_q;
        rw_d     = rw_q;
        if (bus.mem_stall) begin
            valid_d = valid_q;
        end else if (bus.flush) begin
            valid_d = 1'b0;
        end else if (state_q == DONE) begin
            valid_d  = 1'b1;
            result_d = acc_q;
            store_d  = cap_store_q;
            dest_d   = cap_dest_q;
            commit_d = cap_commit_q;
            m2r_d    = cap_m2r_q;
            rw_d     = cap_rw_q;
        end else if ((state_q == IDLE) && bus.ex_valid && !bus.ex_is_mul) begin
            valid_d  = 1'b1;
            result_d = alu_s;
            store_d  = bus.ex_rb_data;
            dest_d   = bus.ex_reg_dest;
            commit_d = bus.ex_commit;
            m2r_d    = bus.ex_mem_to_reg;
            rw_d     = bus.ex_reg_write;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= {CNT_BITS{1'b0}};
            mul_a_q      <= {XLEN{1'b0}};
            mul_b_q      <= {XLEN{1'b0}};
            acc_q        <= {XLEN{1'b0}};
            cap_store_q  <= {XLEN{1'b0}};
            cap_dest_q   <= {REG_BITS{1'b0}};
            cap_commit_q <= 1'b0;
            cap_m2r_q    <= 1'b0;
            cap_rw_q     <= 1'b0;
            valid_q      <= 1'b0;
            result_q     <= {XLEN{1'b0}};
            store_q      <= {XLEN{1'b0}};
            dest_q       <= {REG_BITS{1'b0}};
            commit_q     <= 1'b0;
            m2r_q        <= 1'b0;
            rw_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            acc_q        <= acc_d;
            cap_store_q  <= cap_store_d;
            cap_dest_q   <= cap_dest_d;
            cap_commit_q <= cap_commit_d;
            cap_m2r_q    <= cap_m2r_d;
            cap_rw_q     <= cap_rw_d;
            valid_q      <= valid_d;
            result_q     <= result_d;
            store_q      <= store_d;
            dest_q       <= dest_d;
            commit_q     <= commit_d;
            m2r_q        <= m2r_d;
            rw_q         <= rw_d;
        end
    end

    assign bus.stall          = stall_s;
    assign bus.mem_valid      = valid_q;
    assign bus.mem_result     = result_q;
    assign bus.mem_store_data = store_q;
    assign bus.mem_reg_dest   = dest_q;
    assign bus.mem_commit     = commit_q;
    assign bus.mem_mem_to_reg = m2r_q;
    assign bus.mem_reg_write  = rw_q;
endmodule

// File: tb/tb_cpu_execute_stage.sv
// Self-checking bench for cpu_execute_stage: directed and random ALU/MUL traffic against an
// arithmetic reference, plus memory-stall, flush and mid-multiply reset scenarios.
module tb_cpu_execute_stage;
    localparam int XLEN     = 32;
    localparam int REG_BITS = 5;
    localparam int OUT_W    = 2*XLEN + REG_BITS + 4;

    typedef logic [OUT_W-1:0] out_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    cpu_execute_stage_if #(.XLEN(XLEN), .REG_BITS(REG_BITS)) bus();

    cpu_execute_stage #(.XLEN(XLEN), .REG_BITS(REG_BITS)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Reference: results are true arithmetic reduced modulo 2^XLEN.
    function automatic logic [XLEN-1:0] ref_alu(input logic [1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] w;
        case (op)
            2'b00:   w = {{XLEN{1'b0}}, a} + {{XLEN{1'b0}}, b};
            2'b01:   w = {{XLEN{1'b0}}, a} - {{XLEN{1'b0}}, b};
            2'b10:   w = {{XLEN{1'b0}}, a & b};
            default: w = {{XLEN{1'b0}}, a | b};
        endcase
        return w[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] ref_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] w;
        w = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        return w[XLEN-1:0];
    endfunction

    function automatic out_t exp_out(input logic v, input logic [XLEN-1:0] res,
                                     input logic [XLEN-1:0] st, input logic [REG_BITS-1:0] d,
                                     input logic c, input logic m, input logic w);
        return {v, res, st, d, c, m, w};
    endfunction

    function automatic out_t observed();
        return {bus.mem_valid, bus.mem_result, bus.mem_store_data, bus.mem_reg_dest,
                bus.mem_commit, bus.mem_mem_to_reg, bus.mem_reg_write};
    endfunction

    task automatic drive_idle();
        bus.ex_valid = 1'b0; bus.ex_alu_op = 2'b00; bus.ex_is_mul = 1'b0; bus.ex_reg_b = 1'b0;
        bus.ex_ra_data = 32'h0; bus.ex_rb_data = 32'h0; bus.ex_offset = 32'h0;
        bus.ex_reg_dest = 5'd0; bus.ex_commit = 1'b0; bus.ex_mem_to_reg = 1'b0;
        bus.ex_reg_write = 1'b0; bus.flush = 1'b0; bus.mem_stall = 1'b0;
    endtask

    task automatic present(input logic [1:0] op, input logic is_mul, input logic reg_b,
                           input logic [XLEN-1:0] ra, input logic [XLEN-1:0] rb,
                           input logic [XLEN-1:0] off, input logic [REG_BITS-1:0] dest,
                           input logic c, input logic m, input logic w);
        bus.ex_valid = 1'b1; bus.ex_alu_op = op; bus.ex_is_mul = is_mul; bus.ex_reg_b = reg_b;
        bus.ex_ra_data = ra; bus.ex_rb_data = rb; bus.ex_offset = off; bus.ex_reg_dest = dest;
        bus.ex_commit = c; bus.ex_mem_to_reg = m; bus.ex_reg_write = w;
    endtask

    // One ALU instruction: presented at a falling edge, checked one rising edge later.
    task automatic do_alu(input string name, input logic [1:0] op, input logic reg_b,
                          input logic [XLEN-1:0] ra, input logic [XLEN-1:0] rb,
                          input logic [XLEN-1:0] off, input logic [REG_BITS-1:0] dest,
                          input logic c, input logic m, input logic w,
                          output logic [XLEN-1:0] got_res);
        out_t exp;
        exp = exp_out(1'b1, ref_alu(op, ra, reg_b ? rb : off), rb, dest, c, m, w);
        @(negedge clock);
        present(op, 1'b0, reg_b, ra, rb, off, dest, c, m, w);
        #1;
        tests_run++;
        if (bus.stall !== 1'b0) begin
            tests_failed++; $display("FAIL %s_stall got=%b exp=0", name, bus.stall);
        end
        @(posedge clock); #1;
        tests_run++;
        if (observed() !== exp) begin
            tests_failed++; $display("FAIL %s got=%h exp=%h", name, observed(), exp);
        end
        got_res = bus.mem_result;
    endtask

    // One MUL: checks stall length, result edge and result/control contents.
    task automatic do_mul(input string name, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [REG_BITS-1:0] dest, output logic [XLEN-1:0] got_res);
        int   edge_n, stall_n;
        out_t got, exp;
        edge_n = 0; stall_n = 0; got = '0;
        exp = exp_out(1'b1, ref_mul(a, b), b, dest, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        present(2'b00, 1'b1, 1'b1, a, b, 32'h0, dest, 1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 40; e++) begin
            #1;
            if (bus.stall === 1'b1) stall_n++;
            @(posedge clock); #1;
            if (bus.mem_valid === 1'b1) begin
                edge_n = e; got = observed(); break;
            end
            @(negedge clock);
        end
        tests_run++;
        if (edge_n != XLEN + 2) begin
            tests_failed++; $display("FAIL %s_latency got=%0d exp=%0d", name, edge_n, XLEN + 2);
        end
        tests_run++;
        if (stall_n != XLEN + 1) begin
            tests_failed++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", name, stall_n, XLEN + 1);
        end
        tests_run++;
        if (got !== exp) begin
            tests_failed++; $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
        got_res = got[OUT_W-2 -: XLEN];
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (bus.mem_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++; $display("FAIL %s got=%0d valid cycles exp=0", name, seen);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        @(negedge clock); #1;
        tests_run++;
        if (observed() !== out_t'(0)) begin
            tests_failed++; $display("FAIL reset_outputs got=%h exp=0", observed());
        end
        tests_run++;
        if (bus.stall !== 1'b0) begin
            tests_failed++; $display("FAIL reset_stall got=%b exp=0", bus.stall);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [XLEN-1:0] r;
        do_alu("add", 2'b00, 1'b1, 32'd5, 32'd7, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, r);
        tests_run++;
        if (r !== 32'd12) begin tests_failed++; $display("FAIL add_const got=%h exp=c", r); end
        do_alu("sub", 2'b01, 1'b1, 32'd3, 32'd5, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, r);
        tests_run++;
        if (r !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL sub_const got=%h exp=fffffffe", r); end
        do_alu("and", 2'b10, 1'b1, 32'hF0F0, 32'hFF00, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, r);
        tests_run++;
        if (r !== 32'hF000) begin tests_failed++; $display("FAIL and_const got=%h exp=f000", r); end
        do_alu("or", 2'b11, 1'b1, 32'hF0F0, 32'hFF00, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, r);
        tests_run++;
        if (r !== 32'hFFF0) begin tests_failed++; $display("FAIL or_const got=%h exp=fff0", r); end
        for (int i = 0; i < 24; i++) begin
            do_alu("alu_rand", 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), r);
        end
        @(negedge clock);
        drive_idle();
        @(posedge clock); #1;
        tests_run++;
        if (bus.mem_valid !== 1'b0) begin
            tests_failed++; $display("FAIL invalid_bubble got=%b exp=0", bus.mem_valid);
        end
    endtask

    task automatic test_load();
        logic [XLEN-1:0] r;
        do_alu("load", 2'b00, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd9, 1'b1, 1'b1, 1'b1, r);
        tests_run++;
        if ((r !== 32'hFC) || (bus.mem_commit !== 1'b1)) begin
            tests_failed++; $display("FAIL load_addr got=%h/%b exp=fc/1", r, bus.mem_commit);
        end
    endtask

    task automatic test_mul();
        logic [XLEN-1:0] r;
        do_mul("mul_7x6", 32'd7, 32'd6, 5'd5, r);
        tests_run++;
        if (r !== 32'd42) begin tests_failed++; $display("FAIL mul_7x6_const got=%h exp=2a", r); end
        do_mul("mul_wrap", 32'hFFFF_FFFF, 32'd2, 5'd6, r);
        tests_run++;
        if (r !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mul_wrap_const got=%h exp=fffffffe", r); end
        for (int i = 0; i < 4; i++) do_mul("mul_rand", $urandom, $urandom, 5'($urandom), r);
        @(negedge clock);
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] r;
        do_alu("b2b_alu0", 2'b00, 1'b1, 32'd100, 32'd23, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, r);
        do_mul("b2b_mul", 32'd1234, 32'd5678, 5'd8, r);
        do_alu("b2b_alu1", 2'b01, 1'b0, 32'd50, 32'd0, 32'd8, 5'd10, 1'b0, 1'b0, 1'b1, r);
        @(negedge clock);
        drive_idle();
    endtask

    task automatic test_mem_stall();
        logic [XLEN-1:0] r;
        out_t held;
        do_alu("hold_pre", 2'b00, 1'b1, 32'd10, 32'd20, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, r);
        held = exp_out(1'b1, 32'd30, 32'd20, 5'd11, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        present(2'b01, 1'b0, 1'b1, 32'd100, 32'd1, 32'h0, 5'd12, 1'b0, 1'b0, 1'b1);
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (bus.stall !== 1'b1) begin tests_failed++; $display("FAIL hold_stall got=%b exp=1", bus.stall); end
            @(posedge clock); #1;
            tests_run++;
            if (observed() !== held) begin tests_failed++; $display("FAIL hold_out got=%h exp=%h", observed(), held); end
            @(negedge clock);
        end
        bus.mem_stall = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (observed() !== exp_out(1'b1, 32'd99, 32'd1, 5'd12, 1'b0, 1'b0, 1'b1)) begin
            tests_failed++; $display("FAIL hold_release got=%h", observed());
        end
        // MUL reaching DONE while memory is stalled.
        @(negedge clock);
        present(2'b00, 1'b1, 1'b1, 32'd9, 32'd5, 32'h0, 5'd13, 1'b0, 1'b0, 1'b1);
        repeat (XLEN + 1) @(posedge clock);
        @(negedge clock);
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (bus.stall !== 1'b1) begin tests_failed++; $display("FAIL mulhold_stall got=%b exp=1", bus.stall); end
            @(posedge clock); #1;
            tests_run++;
            if (bus.mem_valid !== 1'b0) begin tests_failed++; $display("FAIL mulhold_valid got=%b exp=0", bus.mem_valid); end
            @(negedge clock);
        end
        bus.mem_stall = 1'b0;
        #1;
        tests_run++;
        if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL mulhold_release_stall got=%b exp=0", bus.stall); end
        @(posedge clock); #1;
        tests_run++;
        if (observed() !== exp_out(1'b1, 32'd45, 32'd5, 5'd13, 1'b0, 1'b0, 1'b1)) begin
            tests_failed++; $display("FAIL mulhold_result got=%h", observed());
        end
        @(negedge clock);
        drive_idle();
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] r;
        // Abort while BUSY with count=10 (11 edges after acceptance).
        @(negedge clock);
        present(2'b00, 1'b1, 1'b1, 32'd123, 32'd456, 32'h0, 5'd14, 1'b0, 1'b0, 1'b1);
        repeat (11) @(posedge clock);
        @(negedge clock);
        bus.flush = 1'b1;
        #1;
        tests_run++;
        if (bus.stall !== 1'b0) begin tests_failed++; $display("FAIL flush_busy_stall got=%b exp=0", bus.stall); end
        @(posedge clock); #1;
        tests_run++;
        if (bus.mem_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_busy_valid got=%b exp=0", bus.mem_valid); end
        @(negedge clock);
        drive_idle();
        expect_quiet("flush_busy_no_result", 40);
        do_alu("flush_after", 2'b00, 1'b1, 32'd1, 32'd2, 32'h0, 5'd15, 1'b0, 1'b0, 1'b1, r);
        // Flush beats completion in DONE.
        @(negedge clock);
        present(2'b00, 1'b1, 1'b1, 32'd3, 32'd3, 32'h0, 5'd16, 1'b0, 1'b0, 1'b1);
        repeat (XLEN + 1) @(posedge clock);
        @(negedge clock);
        bus.flush = 1'b1;
        @(posedge clock); #1;
        tests_run++;
        if (bus.mem_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_done_valid got=%b exp=0", bus.mem_valid); end
        @(negedge clock);
        drive_idle();
        expect_quiet("flush_done_no_result", 5);
        // Flush on an ALU instruction.
        @(negedge clock);
        present(2'b00, 1'b0, 1'b1, 32'd8, 32'd8, 32'h0, 5'd17, 1'b0, 1'b0, 1'b1);
        bus.flush = 1'b1;
        @(posedge clock); #1;
        tests_run++;
        if (bus.mem_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_alu_valid got=%b exp=0", bus.mem_valid); end
        @(negedge clock);
        drive_idle();
    endtask

    task automatic test_reset_mid_mul();
        logic [XLEN-1:0] r;
        do_alu("rst_pre", 2'b11, 1'b1, 32'hA5A5_0000, 32'h0000_5A5A, 32'h0, 5'd18, 1'b1, 1'b1, 1'b1, r);
        @(negedge clock);
        present(2'b00, 1'b1, 1'b1, 32'd77, 32'd88, 32'h0, 5'd19, 1'b0, 1'b0, 1'b1);
        repeat (15) @(posedge clock);
        @(negedge clock);
        drive_idle();
        reset = 1'b1;
        #1;
        tests_run++;
        if ((observed() !== out_t'(0)) || (bus.stall !== 1'b0)) begin
            tests_failed++; $display("FAIL reset_mid_mul got=%h/%b exp=0/0", observed(), bus.stall);
        end
        @(negedge clock);
        reset = 1'b0;
        expect_quiet("reset_mid_mul_no_result", 40);
        do_alu("rst_after", 2'b00, 1'b1, 32'd40, 32'd2, 32'h0, 5'd20, 1'b0, 1'b0, 1'b1, r);
        @(negedge clock);
        drive_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        test_reset();
        test_alu();
        test_load();
        test_mul();
        test_back_to_back();
        test_mem_stall();
        test_flush();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
